// File: rtl/student_dma_mem.sv
// ============================================================================
// Module   : student_dma_mem (plus tlul_pkg)
// Purpose  : TL-UL device-side word memory for the DMA host port. Serves
//            Get, PutFullData and PutPartialData and returns responses in
//            order through a small response FIFO. Because of that FIFO,
//            a_ready backpressure behaves like a real device.
// Ports    : clk_i   - clock, all state on the rising edge
//            rst_ni  - asynchronous active-low reset
//            tl_i    - TL-UL channel A request plus d_ready
//            tl_o    - TL-UL channel D response plus a_ready
// Options  : STUDENT_DMA_MEM_STALL_EN - adds a 16-bit Fibonacci LFSR that
//            masks a_ready pseudo-randomly to stress the host handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module student_dma_mem #(
  parameter int unsigned MemDepth  = 1024,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int unsigned RespDepth = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o
);

  import tlul_pkg::*;

  localparam int unsigned AW = $clog2(MemDepth);
  localparam int unsigned PW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam logic [32:0] MEM_BYTES = 33'(MemDepth) * 33'd4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  // Storage array; intentionally not reset.
  logic [31:0] mem [MemDepth];

  rsp_t          fifo_q [RespDepth];
  rsp_t          fifo_d [RespDepth];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          a_ready;
  logic          accept;
  logic          pop;
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          is_get, is_pfd, is_ppd;
  logic          req_err;
  logic          wr_en;
  rsp_t          push_rsp;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RespDepth - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef STUDENT_DMA_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign a_ready = (count_q < CW'(RespDepth)) && !lfsr_q[0];
`else
  assign a_ready = (count_q < CW'(RespDepth));
`endif

  assign accept = tl_i.a_valid && a_ready;
  assign pop    = (count_q != '0) && tl_i.d_ready;

  // Request decode and response construction.
  always_comb begin
    off    = tl_i.a_address - BaseAddr;
    idx    = off[AW+1:2];
    is_get = (tl_i.a_opcode == Get);
    is_pfd = (tl_i.a_opcode == PutFullData);
    is_ppd = (tl_i.a_opcode == PutPartialData);

    req_err = ({1'b0, off} >= MEM_BYTES)
            || (tl_i.a_address[1:0] != 2'b00)
            || (tl_i.a_size == 2'd3)
            || !(is_get || is_pfd || is_ppd)
            || (is_pfd && (tl_i.a_size == 2'd2) && (tl_i.a_mask != 4'hF));

    wr_en = accept && !req_err && (is_pfd || is_ppd);

    push_rsp.opcode = is_get ? AccessAckData : AccessAck;
    push_rsp.size   = tl_i.a_size;
    push_rsp.source = tl_i.a_source;
    push_rsp.error  = req_err;
    push_rsp.data   = (is_get && !req_err) ? mem[idx] : 32'h0;
  end

  // FIFO next-state.
  always_comb begin
    for (int i = 0; i < int'(RespDepth); i++) fifo_d[i] = fifo_q[i];
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (accept) begin
      fifo_d[wr_ptr_q] = push_rsp;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RespDepth); i++) fifo_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < int'(RespDepth); i++) fifo_q[i] <= fifo_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Byte-lane writes; a following read of the same word sees the new data.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_i.a_mask[b]) mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end

  // D channel shows the FIFO head; fields are forced to 0 when empty.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    tl_o.d_valid = (count_q != '0);
    if (count_q != '0) begin
      tl_o.d_opcode = fifo_q[rd_ptr_q].opcode;
      tl_o.d_size   = fifo_q[rd_ptr_q].size;
      tl_o.d_source = fifo_q[rd_ptr_q].source;
      tl_o.d_data   = fifo_q[rd_ptr_q].data;
      tl_o.d_error  = fifo_q[rd_ptr_q].error;
    end
  end

  logic unused_param;
  assign unused_param = ^tl_i.a_param;

endmodule

`default_nettype wire

// File: tb/tb_student_dma_mem.sv
`default_nettype none

module tb_student_dma_mem;

  import tlul_pkg::*;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          RDEPTH = 2;

  logic     clk = 1'b0;
  logic     rst_ni;
  tl_h2d_t  tl_i;
  tl_d2h_t  tl_o;

  always #5 clk = ~clk;

  student_dma_mem #(
    .MemDepth (DEPTH),
    .BaseAddr (BASE),
    .RespDepth(RDEPTH)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .tl_i  (tl_i),
    .tl_o  (tl_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
    logic        chk_op;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [int];
  logic [31:0] pop_log [$];
  logic        pop_err [$];
  int          total = 0;
  int          bad   = 0;
  logic        last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: derive the response straight from the access rules.
  task automatic model_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [1:0] size, input logic [3:0] mask,
                           input logic [31:0] data, input logic [7:0] src,
                           output exp_t e);
    longint off;
    int     w;
    logic   legal_op;
    logic   err;
    logic [31:0] cur;
    off      = longint'(addr) - longint'(BASE);
    legal_op = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
    err      = (off < 0) || (off >= longint'(DEPTH) * 4) || (addr % 4 != 0) ||
               (size > 2) || !legal_op || (op == 3'd0 && size == 2 && mask != 4'hF);
    w        = int'(off / 4);
    e.op     = (op == 3'd4) ? 3'd1 : 3'd0;
    e.chk_op = legal_op;
    e.size   = size;
    e.src    = src;
    e.err    = err;
    e.data   = 32'h0;
    if (!err) begin
      if (op == 3'd4) begin
        e.data = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
      end else begin
        cur = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
        for (int b = 0; b < 4; b++) if (mask[b]) cur[8*b +: 8] = data[8*b +: 8];
        ref_mem[w] = cur;
      end
    end
  endtask

  // One clock: observe handshakes at the falling edge, then advance.
  task automatic clk_step();
    exp_t e;
    @(negedge clk);
    chk("d_valid", {31'b0, tl_o.d_valid}, {31'b0, exp_q.size() != 0});
`ifdef STUDENT_DMA_MEM_STALL_EN
    if (tl_o.a_ready) chk("a_ready_room", {31'b0, exp_q.size() < RDEPTH}, 32'd1);
`else
    chk("a_ready", {31'b0, tl_o.a_ready}, {31'b0, exp_q.size() < RDEPTH});
`endif
    if (tl_o.d_valid && exp_q.size() > 0) begin
      if (exp_q[0].chk_op) chk("d_opcode", {29'b0, tl_o.d_opcode}, {29'b0, exp_q[0].op});
      chk("d_error",  {31'b0, tl_o.d_error}, {31'b0, exp_q[0].err});
      chk("d_data",   tl_o.d_data, exp_q[0].data);
      chk("d_size",   {30'b0, tl_o.d_size}, {30'b0, exp_q[0].size});
      chk("d_source", {24'b0, tl_o.d_source}, {24'b0, exp_q[0].src});
      if (tl_i.d_ready) begin
        pop_log.push_back(tl_o.d_data);
        pop_err.push_back(tl_o.d_error);
        void'(exp_q.pop_front());
      end
    end
    last_acc = tl_i.a_valid && tl_o.a_ready;
    if (last_acc) begin
      model_req(tl_i.a_opcode, tl_i.a_address, tl_i.a_size, tl_i.a_mask,
                tl_i.a_data, tl_i.a_source, e);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] size, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = size;
    tl_i.a_address = addr;
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr,
                      input logic [1:0] size, input logic [3:0] mask,
                      input logic [31:0] data, input logic [7:0] src);
    set_req(op, addr, size, mask, data, src);
    for (int i = 0; i < 50; i++) begin
      clk_step();
      if (last_acc) break;
    end
    chk("send_accepted", {31'b0, last_acc}, 32'd1);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) clk_step();
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] desc [4];
    logic [2:0]  op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  mask;
    int          kind;

    desc[0] = 32'h1; desc[1] = 32'h10; desc[2] = 32'h100; desc[3] = 32'h200;
    tl_i   = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_valid", {31'b0, tl_o.d_valid}, 32'd0);
    chk("rst_a_ready", {31'b0, tl_o.a_ready}, 32'd1);
    chk("rst_d_data",  tl_o.d_data, 32'd0);
    chk("rst_d_error", {31'b0, tl_o.d_error}, 32'd0);
    rst_ni       = 1'b1;
    tl_i.d_ready = 1'b1;

    // Descriptor read
    for (int i = 0; i < 4; i++) send(PutFullData, 32'(i * 4), 2'd2, 4'hF, desc[i], 8'(i));
    drain();
    pop_log.delete(); pop_err.delete();
    for (int i = 0; i < 4; i++) send(Get, 32'(i * 4), 2'd2, 4'hF, 32'h0, 8'(8'h20 + i));
    drain();
    for (int i = 0; i < 4; i++) chk("desc_data", pop_log[i], desc[i]);

    // Memset burst then readback
    for (int i = 0; i < 4; i++) send(PutFullData, 32'h200 + 32'(i * 4), 2'd2, 4'hF, 32'hDEADBEEF, 8'h30);
    drain();
    pop_log.delete(); pop_err.delete();
    for (int i = 0; i < 4; i++) send(Get, 32'h200 + 32'(i * 4), 2'd2, 4'hF, 32'h0, 8'h31);
    drain();
    for (int i = 0; i < 4; i++) chk("memset_data", pop_log[i], 32'hDEADBEEF);

    // Partial write
    send(PutFullData, 32'h40, 2'd2, 4'hF, 32'h11223344, 8'h40);
    send(PutPartialData, 32'h40, 2'd2, 4'b0101, 32'hAABBCCDD, 8'h41);
    send(Get, 32'h40, 2'd2, 4'hF, 32'h0, 8'h42);
    drain();
    chk("partial_data", pop_log[pop_log.size() - 1], 32'h11BB33DD);

    // Backpressure with d_ready low
    pop_log.delete(); pop_err.delete();
    tl_i.d_ready = 1'b0;
    send(Get, 32'h0, 2'd2, 4'hF, 32'h0, 8'h51);
    send(Get, 32'h4, 2'd2, 4'hF, 32'h0, 8'h52);
    set_req(Get, 32'h8, 2'd2, 4'hF, 32'h0, 8'h53);
    for (int i = 0; i < 3; i++) begin
      clk_step();
      chk("bp_no_accept", {31'b0, last_acc}, 32'd0);
      chk("bp_head_data", tl_o.d_data, 32'h1);
    end
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_step();
      if (last_acc) break;
    end
    chk("bp_third_accepted", {31'b0, last_acc}, 32'd1);
    tl_i.a_valid = 1'b0;
    drain();
    for (int i = 0; i < 3; i++) chk("bp_order", pop_log[i], desc[i]);

    // Error cases, memory unchanged afterwards
    pop_log.delete(); pop_err.delete();
    send(Get, BASE + 32'(DEPTH * 4), 2'd2, 4'hF, 32'h0, 8'h60);
    send(Get, 32'h2, 2'd2, 4'hF, 32'h0, 8'h61);
    send(PutFullData, 32'h200, 2'd2, 4'h3, 32'h0, 8'h62);
    send(Get, 32'h200, 2'd2, 4'hF, 32'h0, 8'h63);
    drain();
    for (int i = 0; i < 3; i++) begin
      chk("err_flag", {31'b0, pop_err[i]}, 32'd1);
      chk("err_data", pop_log[i], 32'd0);
    end
    chk("err_mem_kept", pop_log[3], 32'hDEADBEEF);
    chk("err_reread_ok", {31'b0, pop_err[3]}, 32'd0);

    // Reset with two responses pending
    tl_i.d_ready = 1'b0;
    send(PutFullData, 32'h300, 2'd2, 4'hF, 32'h12345678, 8'h70);
    send(Get, 32'h0, 2'd2, 4'hF, 32'h0, 8'h71);
    rst_ni = 1'b0;
    #2;
    chk("mid_rst_d_valid", {31'b0, tl_o.d_valid}, 32'd0);
    chk("mid_rst_a_ready", {31'b0, tl_o.a_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    tl_i.d_ready = 1'b1;
    pop_log.delete(); pop_err.delete();
    send(Get, 32'h300, 2'd2, 4'hF, 32'h0, 8'h72);
    drain();
    chk("rst_mem_kept", pop_log[0], 32'h12345678);

    // Randomized traffic over a prewritten window
    for (int i = 0; i < 16; i++) send(PutFullData, 32'h800 + 32'(i * 4), 2'd2, 4'hF, $urandom, 8'h80);
    drain();
    tl_i.a_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!tl_i.a_valid || last_acc) begin
        kind = int'($urandom_range(0, 9));
        addr = 32'h800 + 32'($urandom_range(0, 15) * 4);
        size = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
        mask = 4'($urandom);
        case (kind)
          0, 1, 2, 3: op = Get;
          4, 5: begin op = PutFullData; if ($urandom_range(0, 3) != 0) mask = 4'hF; end
          6, 7: op = PutPartialData;
          8: begin
            op   = Get;
            addr = ($urandom_range(0, 1) == 0) ? BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4)
                                                : addr + 32'($urandom_range(1, 3));
          end
          default: op = 3'($urandom_range(2, 7) == 4 ? 2 : $urandom_range(2, 7));
        endcase
        set_req(op, addr, size, mask, $urandom, 8'($urandom));
        tl_i.a_valid = ($urandom_range(0, 9) < 7);
      end
      tl_i.d_ready = ($urandom_range(0, 9) < 7);
      clk_step();
    end
    tl_i.a_valid = 1'b0;
    tl_i.d_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
